xgemac_wb_cfg_arbiter: RTL and testbench
========================================

Name: xgemac_wb_cfg_arbiter

Overview:
Wishbone master that owns the single XGEMAC register port. After reset it runs a fixed two-write init sequence. It then arbitrates between two host requesters (round-robin) and an internal interrupt-service agent that reads the interrupt-pending register when the MAC raises its interrupt. Sits between host/config logic and the MAC's wishbone slave, in the wb_clk_i domain.

Parameters:
ADDR_W, 8, wishbone address width.
DATA_W, 32, wishbone data width.
CFG_INIT, 32'h0000_0001, value written to config register 0x00 during init (bit0 = tx enable).
IMASK_INIT, 32'h0000_0000, value written to interrupt-mask register 0x10 during init.
IRQ_ADDR, 8'h08, address read on interrupt service (clear-on-read pending register).
TIMEOUT_CYCLES, 16, ack timeout; used only with the optional feature.

Ports:
wb_clk_i in 1: the only clock.
wb_rst_i in 1: synchronous reset, active-high.
reqN_valid in 1 (N=0,1): host request valid.
reqN_we in 1: 1 = write, 0 = read.
reqN_adr in ADDR_W: register address.
reqN_wdata in DATA_W: write data.
reqN_ready out 1: request accepted this cycle.
reqN_rvalid out 1: one-cycle completion pulse.
reqN_rdata out DATA_W: read data; valid with rvalid.
wb_adr_o out ADDR_W, wb_dat_o out DATA_W, wb_we_o out 1, wb_stb_o out 1, wb_cyc_o out 1: master outputs.
wb_dat_i in DATA_W, wb_ack_i in 1: slave response.
wb_int_i in 1: MAC interrupt, level.
init_done out 1: init sequence complete.
int_status_o out DATA_W: last interrupt-pending value read.
int_valid_o out 1: one-cycle pulse when int_status_o updates.
err_o out 1: timeout pulse (optional feature).

Behaviour:
- Reset values: all outputs 0; FSM = INIT0; rr_last = 1 (req0 wins first tie); irq_armed = 1.
- Reset mid-transaction: cyc/stb drop at the reset edge, pending requester gets no rvalid, init sequence reruns.
- FSM states: INIT0, INIT1, IDLE, BUS, IRQ.
- INIT0: drive write 0x00 <= CFG_INIT. On ack, go to INIT1.
- INIT1: drive write 0x10 <= IMASK_INIT. On ack, go to IDLE and set init_done (held until reset).
- No reqN_ready before init_done.
- IDLE arbitration, priority order: (1) wb_int_i && irq_armed goes to IRQ; (2) only one reqN_valid grants it; (3) both valid grants the requester != rr_last.
- On a host grant: reqN_ready = 1 combinationally in the same cycle, request fields registered, rr_last <= N, go to BUS.
- Bus transaction: cyc/stb/we/adr/dat asserted from the cycle after grant (INIT states assert from the state-entry cycle) and held stable until the cycle wb_ack_i is sampled high.
- Deassertion: cyc/stb drop on the edge after ack.
- Spacing: at least one idle cycle with cyc = 0 between transactions.
- Completion: reqN_rvalid pulses the cycle after ack. reqN_rdata = wb_dat_i captured at ack for reads, 0 for writes. rdata holds until the next completion.
- IRQ: read IRQ_ADDR. The cycle after ack: int_status_o <= data, int_valid_o pulses, irq_armed <= 0, return to IDLE.
- irq_armed sets again when wb_int_i is sampled 0. A level held high across the read is not re-serviced.
- A requester is not granted while it is in flight; the other requester waits (no starvation: alternates on ties).
- wb_ack_i while cyc = 0 is ignored.
- Sustained throughput: one transaction per 3 cycles with zero-wait-state ack.

Optional Feature:
XGEMAC_WB_TIMEOUT_EN.
- Defined: a counter starts at cyc assertion. If no ack after TIMEOUT_CYCLES cycles, cyc/stb drop, err_o pulses 1 cycle and the FSM proceeds as if acked with data 0. Host gets rvalid with rdata 0; IRQ gives int_valid with 0; INIT advances.
- Undefined: the master waits for ack indefinitely and err_o is tied 0.

Test Plan:
- Reset release, ack 1 cycle after stb -> writes 0x00 <= 0x1 then 0x10 <= 0x0, in order; init_done rises the cycle after the second ack.
- req0 read 0x0C, slave returns 32'hA5A5_0003 -> req0_ready at grant; cyc from grant+1; req0_rvalid 1 cycle after ack with rdata 32'hA5A5_0003.
- req0 and req1 held valid for 4 grants -> grant order 0,1,0,1; each cyc burst separated by ≥1 cyc = 0 cycle.
- wb_int_i high while req1 valid in IDLE -> IRQ read of 0x08 first, int_status_o = returned 32'h0000_0010; then req1 is served; no second IRQ read until wb_int_i has gone low.
- wb_rst_i asserted during req1 BUS with no ack -> cyc = 0 the next cycle, no req1_rvalid, init writes repeat.
- With XGEMAC_WB_TIMEOUT_EN, ack withheld on a req0 write -> cyc drops after 16 cycles; err_o and req0_rvalid pulse with rdata 0.

Source files
------------

// File: rtl/xgemac_wb_cfg_arbiter.sv
// Wishbone master for the XGEMAC register port: two init writes, then round-robin
// host access plus interrupt-pending reads. Optional ack timeout: XGEMAC_WB_TIMEOUT_EN.
module xgemac_wb_cfg_arbiter #(
    parameter int                ADDR_W         = 8,
    parameter int                DATA_W         = 32,
    parameter logic [DATA_W-1:0] CFG_INIT       = 32'h0000_0001,
    parameter logic [DATA_W-1:0] IMASK_INIT     = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] IRQ_ADDR       = 8'h08,
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_adr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_adr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_int_i,
    output logic              init_done,
    output logic [DATA_W-1:0] int_status_o,
    output logic              int_valid_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] CFG_ADDR   = '0;
    localparam logic [ADDR_W-1:0] IMASK_ADDR = ADDR_W'('h10);

    typedef enum logic [2:0] {INIT0, INIT1, IDLE, BUS, IRQ} state_t;

    state_t              state_q, state_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic                owner_q, owner_d;
    logic                rr_last_q, rr_last_d;
    logic                irq_armed_q, irq_armed_d;
    logic                init_done_q, init_done_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [DATA_W-1:0]   int_status_q, int_status_d;
    logic                int_valid_q, int_valid_d;
    logic                gnt0, gnt1;
    logic                tmo_hit;
    logic                done;
    logic [DATA_W-1:0]   rsp_data;

    // A timed-out cycle completes exactly like an ack carrying zero data.
    assign done     = cyc_q && (wb_ack_i || tmo_hit);
    assign rsp_data = wb_ack_i ? wb_dat_i : '0;

`ifdef XGEMAC_WB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !cyc_q) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
        if (wb_rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= cyc_q && tmo_hit && !wb_ack_i;
        end
    end

    assign tmo_hit = cyc_q && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err_o   = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= INIT0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            owner_q      <= 1'b0;
            rr_last_q    <= 1'b1;
            irq_armed_q  <= 1'b1;
            init_done_q  <= 1'b0;
            rvalid_q     <= 2'b00;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            int_status_q <= '0;
            int_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            owner_q      <= owner_d;
            rr_last_q    <= rr_last_d;
            irq_armed_q  <= irq_armed_d;
            init_done_q  <= init_done_d;
            rvalid_q     <= rvalid_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            int_status_q <= int_status_d;
            int_valid_q  <= int_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        owner_d      = owner_q;
        rr_last_d    = rr_last_q;
        irq_armed_d  = irq_armed_q | ~wb_int_i;
        init_done_d  = init_done_q;
        rvalid_d     = 2'b00;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        int_status_d = int_status_q;
        int_valid_d  = 1'b0;
        gnt0         = 1'b0;
        gnt1         = 1'b0;

        case (state_q)
            // Init states launch with cyc low for one cycle, which also gives
            // the mandatory idle gap between the two init writes.
            INIT0: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = CFG_ADDR;
                    dat_d = CFG_INIT;
                end else if (done) begin
                    cyc_d   = 1'b0;
                    state_d = INIT1;
                end
            end
            INIT1: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = IMASK_ADDR;
                    dat_d = IMASK_INIT;
                end else if (done) begin
                    cyc_d       = 1'b0;
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                if (wb_int_i && irq_armed_q) begin
                    state_d = IRQ;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = IRQ_ADDR;
                    dat_d   = '0;
                end else begin
                    gnt0 = req0_valid && (!req1_valid || rr_last_q);
                    gnt1 = req1_valid && !gnt0;
                    if (gnt0 || gnt1) begin
                        state_d   = BUS;
                        cyc_d     = 1'b1;
                        owner_d   = gnt1;
                        rr_last_d = gnt1;
                        we_d      = gnt1 ? req1_we    : req0_we;
                        adr_d     = gnt1 ? req1_adr   : req0_adr;
                        dat_d     = gnt1 ? req1_wdata : req0_wdata;
                    end
                end
            end
            // BUS/IRQ keep the state for one cyc-low completion cycle after the
            // ack, so back-to-back transactions land every third cycle.
            BUS: begin
                if (!cyc_q) begin
                    state_d = IDLE;
                end else if (done) begin
                    cyc_d = 1'b0;
                    if (owner_q) begin
                        rvalid_d = 2'b10;
                        rdata1_d = we_q ? '0 : rsp_data;
                    end else begin
                        rvalid_d = 2'b01;
                        rdata0_d = we_q ? '0 : rsp_data;
                    end
                end
            end
            IRQ: begin
                if (!cyc_q) begin
                    state_d = IDLE;
                end else if (done) begin
                    cyc_d        = 1'b0;
                    int_status_d = rsp_data;
                    int_valid_d  = 1'b1;
                    irq_armed_d  = ~wb_int_i;
                end
            end
            default: begin
                state_d = INIT0;
                cyc_d   = 1'b0;
            end
        endcase
    end

    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_we_o      = we_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign req0_rvalid  = rvalid_q[0];
    assign req1_rvalid  = rvalid_q[1];
    assign req0_rdata   = rdata0_q;
    assign req1_rdata   = rdata1_q;
    assign init_done    = init_done_q;
    assign int_status_o = int_status_q;
    assign int_valid_o  = int_valid_q;

endmodule

// File: tb/tb_xgemac_wb_cfg_arbiter.sv
// Random host/interrupt/slave traffic for xgemac_wb_cfg_arbiter, checked against a
// transaction-level model of the arbitration and completion rules.
module tb_xgemac_wb_cfg_arbiter;

    localparam int TMO = 16;
`ifdef XGEMAC_WB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int K_INIT0 = 0, K_INIT1 = 1, K_H0 = 2, K_H1 = 3, K_IRQ = 4;

    logic        wb_clk_i, wb_rst_i;
    logic        req0_valid, req0_we, req0_ready, req0_rvalid;
    logic [7:0]  req0_adr;
    logic [31:0] req0_wdata, req0_rdata;
    logic        req1_valid, req1_we, req1_ready, req1_rvalid;
    logic [7:0]  req1_adr;
    logic [31:0] req1_wdata, req1_rdata;
    logic [7:0]  wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i, int_status_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_int_i;
    logic        init_done, int_valid_o, err_o;

    xgemac_wb_cfg_arbiter dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_adr(req0_adr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_adr(req1_adr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
        .req1_rdata(req1_rdata),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_int_i(wb_int_i), .init_done(init_done),
        .int_status_o(int_status_o), .int_valid_o(int_valid_o), .err_o(err_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int n_chk, n_err, cyc_n;

    // model of the master as seen from outside
    bit          m_busy, m_started, m_init_done, m_armed, m_rr_last;
    int          m_kind, m_since, m_free, m_hi, m_wait;
    logic [7:0]  m_adr;
    logic        m_we;
    logic [31:0] m_dat, m_int;
    logic [31:0] m_rdata [2];
    logic [1:0]  e_rv;
    bit          e_iv, e_err;

    // host request sources
    bit          h_pend [2];
    logic        h_we   [2];
    logic [7:0]  h_adr  [2];
    logic [31:0] h_dat  [2];
    bit          rst_test;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_busy = 1; m_kind = K_INIT0; m_adr = 8'h00; m_we = 1; m_dat = 32'h1;
        m_started = 0; m_since = cyc_n; m_hi = 0; m_wait = 0; m_free = 0;
        m_init_done = 0; m_armed = 1; m_rr_last = 1;
        m_rdata[0] = '0; m_rdata[1] = '0; m_int = '0;
        e_rv = '0; e_iv = 0; e_err = 0;
        h_pend[0] = 0; h_pend[1] = 0;
    endtask

    task automatic do_reset(input int n);
        wb_rst_i = 1; req0_valid = 0; req1_valid = 0; wb_ack_i = 0; wb_int_i = 0;
        repeat (n) begin
            @(negedge wb_clk_i);
            cyc_n++;
            chk("rst_cyc", wb_cyc_o, 0);       chk("rst_stb", wb_stb_o, 0);
            chk("rst_adr", wb_adr_o, 0);       chk("rst_we", wb_we_o, 0);
            chk("rst_rvalid0", req0_rvalid, 0); chk("rst_rvalid1", req1_rvalid, 0);
            chk("rst_ready0", req0_ready, 0);  chk("rst_ready1", req1_ready, 0);
            chk("rst_rdata0", req0_rdata, 0);  chk("rst_rdata1", req1_rdata, 0);
            chk("rst_init_done", init_done, 0); chk("rst_int_valid", int_valid_o, 0);
            chk("rst_int_status", int_status_o, 0); chk("rst_err", err_o, 0);
        end
        wb_rst_i = 0;
        model_reset();
    endtask

    function automatic int pick_wait();
        if (rst_test && (m_kind == K_H0 || m_kind == K_H1)) return 12;
        if (TMO_EN && $urandom_range(0, 9) == 0) return 100;
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    task automatic complete(input logic [31:0] data, input bit tmo);
        case (m_kind)
            K_INIT0: begin
                m_kind = K_INIT1; m_adr = 8'h10; m_we = 1; m_dat = 32'h0;
                m_started = 0; m_since = cyc_n + 1;
            end
            K_INIT1: begin
                m_busy = 0; m_init_done = 1; m_free = cyc_n + 1;
            end
            K_H0, K_H1: begin
                e_rv[m_kind - K_H0] = 1'b1;
                m_rdata[m_kind - K_H0] = m_we ? 32'h0 : data;
                m_busy = 0; m_free = cyc_n + 2;
            end
            default: begin
                e_iv = 1; m_int = data; m_armed = 0;
                m_busy = 0; m_free = cyc_n + 2;
            end
        endcase
        e_err = tmo;
        m_hi = 0;
    endtask

    // One cycle, evaluated at the negedge: check, then drive the next inputs.
    task automatic step();
        bit ack, tmo, exp_cyc, idle_now, take_irq;
        logic [31:0] rsp;
        int g;
        cyc_n++;
        chk("rvalid0", req0_rvalid, e_rv[0]);
        chk("rvalid1", req1_rvalid, e_rv[1]);
        chk("int_valid", int_valid_o, e_iv);
        chk("err", err_o, e_err);
        chk("rdata0", req0_rdata, m_rdata[0]);
        chk("rdata1", req1_rdata, m_rdata[1]);
        chk("int_status", int_status_o, m_int);
        chk("init_done", init_done, m_init_done);
        e_rv = '0; e_iv = 0; e_err = 0;

        if (m_busy && !m_started && wb_cyc_o === 1'b1 && cyc_n > m_since) m_started = 1;
        if (m_busy && !m_started && cyc_n - m_since > 4) begin
            chk("init_launch", wb_cyc_o, 1);
            m_started = 1;
        end
        exp_cyc = m_busy && m_started;
        chk("cyc", wb_cyc_o, exp_cyc);
        chk("stb", wb_stb_o, exp_cyc);

        ack = 0; tmo = 0; rsp = $urandom;
        if (exp_cyc) begin
            chk("adr", wb_adr_o, m_adr);
            chk("we", wb_we_o, m_we);
            if (m_we) chk("wdat", wb_dat_o, m_dat);
            if (m_hi == 0) m_wait = pick_wait();
            m_hi++;
            if (m_wait == 0) ack = 1; else m_wait--;
            tmo = TMO_EN && !ack && m_hi == TMO;
        end else begin
            ack = ($urandom_range(0, 7) == 0);
        end
        wb_ack_i = ack;
        wb_dat_i = rsp;
        if (exp_cyc && (ack || tmo)) complete(ack ? rsp : 32'h0, tmo);

        if ($urandom_range(0, 24) == 0) wb_int_i = !wb_int_i;
        for (int n = 0; n < 2; n++) begin
            if (!h_pend[n] && $urandom_range(0, 3) == 0) begin
                h_pend[n] = 1;
                h_we[n]   = 1'($urandom);
                h_adr[n]  = 8'($urandom);
                h_dat[n]  = $urandom;
            end
        end
        req0_valid = h_pend[0]; req0_we = h_we[0]; req0_adr = h_adr[0]; req0_wdata = h_dat[0];
        req1_valid = h_pend[1]; req1_we = h_we[1]; req1_adr = h_adr[1]; req1_wdata = h_dat[1];
        #1;

        idle_now = !m_busy && m_init_done && cyc_n >= m_free;
        take_irq = idle_now && wb_int_i && m_armed;
        g = -1;
        if (idle_now && !take_irq) begin
            if (h_pend[0] && h_pend[1]) g = m_rr_last ? 0 : 1;
            else if (h_pend[0])         g = 0;
            else if (h_pend[1])         g = 1;
        end
        chk("ready0", req0_ready, g == 0);
        chk("ready1", req1_ready, g == 1);
        if (take_irq) begin
            m_busy = 1; m_kind = K_IRQ; m_adr = 8'h08; m_we = 0; m_started = 1; m_hi = 0;
        end
        if (g >= 0) begin
            m_busy = 1; m_kind = K_H0 + g; m_started = 1; m_hi = 0;
            m_we = h_we[g]; m_adr = h_adr[g]; m_dat = h_dat[g];
            m_rr_last = (g == 1);
            h_pend[g] = 0;
        end
        if (!wb_int_i) m_armed = 1;
    endtask

    initial begin
        bit fired;
        n_chk = 0; n_err = 0; cyc_n = 0; rst_test = 0;
        req0_we = 0; req0_adr = '0; req0_wdata = '0;
        req1_we = 0; req1_adr = '0; req1_wdata = '0;
        wb_dat_i = '0;
        do_reset(3);
        repeat (1500) begin
            @(negedge wb_clk_i);
            step();
        end

        // reset while a host transaction waits for its ack
        rst_test = 1;
        fired = 0;
        for (int i = 0; i < 2000 && !fired; i++) begin
            @(negedge wb_clk_i);
            step();
            if (m_busy && (m_kind == K_H0 || m_kind == K_H1) && m_hi >= 2) begin
                fired = 1;
                do_reset(2);
            end
        end
        chk("midtxn_reset_reached", fired, 1);
        rst_test = 0;
        repeat (1500) begin
            @(negedge wb_clk_i);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
